// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small circular write FIFO.
// Frames go out LSB first; tx idles high and is driven from a register.
module uart_transmitter #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int DIV = CLOCK_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = PW + 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(FIFO_DEPTH);

  // state   | meaning
  // S_IDLE  | line high, waiting for a queued byte
  // S_START | start bit (low) for DIV cycles
  // S_DATA  | eight data bits, LSB first, DIV cycles each
  // S_STOP  | stop bit (high) for DIV cycles
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            wr_accept;
  logic            pop;
  logic            bit_last;

  assign full      = (count_q == COUNT_FULL);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != S_IDLE) || !empty;
  assign overflow  = overflow_q;
  assign tx        = tx_q;

  assign wr_accept = wr_en && !full;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign bit_last  = (cnt_q == CNT_LAST);

  // FIFO bookkeeping; a pop and a write in the same cycle leave count unchanged
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full);
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = S_START;
      S_START: if (bit_last) state_d = S_DATA;
      S_DATA:  if (bit_last && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic; tx_d is what the line shows from the next cycle on
  always_comb begin
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = (bit_last || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = '0;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (bit_last) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          if (bit_idx_q != 3'd7) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a DIV=4 instance for frame-level checks
// and a default-rate instance for the 50 MHz / 115200 bit timing.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_en_def;
  logic [7:0] wr_data, wr_data_def;
  logic       full, empty, busy, overflow, tx;
  logic       full_def, empty_def, busy_def, overflow_def, tx_def;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLOCK_HZ  (16),
    .BAUD_RATE (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .overflow(overflow),
    .tx      (tx)
  );

  uart_transmitter dut_def (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_def),
    .wr_data (wr_data_def),
    .full    (full_def),
    .empty   (empty_def),
    .busy    (busy_def),
    .overflow(overflow_def),
    .tx      (tx_def)
  );

  // Line level at cycle 'off' (0..39) of a DIV=4 frame carrying b
  function automatic logic frame_bit(input logic [7:0] b, input int off);
    int j;
    j = off / 4;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  task automatic test_reset();
    int lows;
    lows = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_en_def = 1'b0; wr_data_def = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (tx_def !== 1'b1)   begin errors++; $display("FAIL reset_tx_def got %b exp 1", tx_def); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL reset_idle_tx low_cycles got %0d exp 0", lows); end
  endtask

  task automatic test_single_byte();
    logic exp;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      exp = (k >= 2 && k < 42) ? frame_bit(8'hA5, k - 2) : 1'b1;
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL single_tx k=%0d got %b exp %b", k, tx, exp); end
      if (k == 1) begin
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write got %b exp 0", empty); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL single_busy_after_write got %b exp 1", busy); end
      end
      if (k == 2) begin
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %b exp 1", empty); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL single_busy_in_frame got %b exp 1", busy); end
      end
      if (k == 41) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop_end got %b exp 1", busy); end
      end
      if (k == 42) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %b exp 0", busy); end
      end
      if (k == 0) begin wr_en = 1'b1; wr_data = 8'hA5; end
      if (k == 1) wr_en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    for (int k = 0; k < 95; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 42)       exp = frame_bit(8'h55, k - 2);
      else if (k >= 43 && k < 83) exp = frame_bit(8'h0F, k - 43);
      else                        exp = 1'b1;
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL b2b_tx k=%0d got %b exp %b", k, tx, exp); end
      if (k == 2) begin
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL b2b_second_queued got %b exp 0", empty); end
      end
      if (k == 42) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_gap got %b exp 1", busy); end
      end
      if (k == 43) begin
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty_after_pop2 got %b exp 1", empty); end
      end
      if (k == 83) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop got %b exp 0", busy); end
      end
      if (k == 0) begin wr_en = 1'b1; wr_data = 8'h55; end
      if (k == 1) wr_data = 8'h0F;
      if (k == 2) wr_en = 1'b0;
    end
  endtask

  task automatic test_fill_overflow();
    logic exp;
    int   i, off;
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      exp = 1'b1;
      if (k >= 2) begin
        i   = (k - 2) / 41;
        off = (k - 2) % 41;
        if (i < 5 && off < 40) exp = frame_bit(8'(i + 1), off);
      end
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL fill_tx k=%0d got %b exp %b", k, tx, exp); end
      if (k == 4) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_early got %b exp 0", full); end
      end
      if (k == 5) begin
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_full_rise got %b exp 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow_early got %b exp 0", overflow); end
      end
      if (k == 6) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_rise got %b exp 1", overflow); end
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL fill_full_hold got %b exp 1", full); end
      end
      if (k == 42) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_before_pop got %b exp 1", full); end
      end
      if (k == 43) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_fall got %b exp 0", full); end
      end
      if (k == 219) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky got %b exp 1", overflow); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL fill_empty_end got %b exp 1", empty); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL fill_busy_end got %b exp 0", busy); end
      end
      if (k == 0) wr_en = 1'b1;
      if (k < 6)  wr_data = 8'(k + 1);
      if (k == 6) wr_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic exp;
    for (int k = 0; k < 180; k++) begin
      @(negedge clk);
      exp = (k >= 2 && k < 19) ? frame_bit(8'hFF, k - 2) : 1'b1;
      checks++;
      if (tx !== exp) begin errors++; $display("FAIL midrst_tx k=%0d got %b exp %b", k, tx, exp); end
      if (k == 0) begin wr_en = 1'b1; wr_data = 8'hFF; end
      if (k == 1) wr_data = 8'hAA;
      if (k == 2) wr_data = 8'hBB;
      if (k == 3) begin
        wr_en = 1'b0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL midrst_queued got %b exp 0", empty); end
      end
      if (k == 19) begin
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL midrst_tx_async got %b exp 1", tx); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty_async got %b exp 1", empty); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy_async got %b exp 0", busy); end
      end
      if (k == 22) rst_n = 1'b1;
      if (k == 23) begin
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL midrst_empty_release got %b exp 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow_cleared got %b exp 0", overflow); end
      end
      if (k == 179) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_end got %b exp 0", busy); end
      end
    end
  endtask

  task automatic test_default_rate();
    int fall_k, rise_k, drop_k, glitches;
    fall_k = -1; rise_k = -1; drop_k = -1; glitches = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (fall_k < 0 && tx_def === 1'b0) fall_k = k;
      else if (fall_k >= 0 && rise_k < 0 && tx_def === 1'b1) rise_k = k;
      if (rise_k >= 0 && drop_k < 0 && busy_def === 1'b0) drop_k = k;
      if (rise_k >= 0 && tx_def !== 1'b1) glitches++;
      if (k == 0) begin wr_en_def = 1'b1; wr_data_def = 8'h00; end
      if (k == 1) wr_en_def = 1'b0;
      if (drop_k >= 0) break;
    end
    checks++; if (fall_k != 2)              begin errors++; $display("FAIL def_fall_cycle got %0d exp 2", fall_k); end
    checks++; if (rise_k - fall_k != 3906)  begin errors++; $display("FAIL def_low_len got %0d exp 3906", rise_k - fall_k); end
    checks++; if (drop_k - rise_k != 434)   begin errors++; $display("FAIL def_stop_len got %0d exp 434", drop_k - rise_k); end
    checks++; if (glitches != 0)            begin errors++; $display("FAIL def_stop_glitch got %0d exp 0", glitches); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fill_overflow();
    test_reset_mid_frame();
    test_default_rate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial 8N1 UART transmitter with a small write FIFO. It is the transmit counterpart of the computer's UART receive path and drives the `tx` pin at `BAUD_RATE` from the system clock. The CPU side pushes bytes with a single-cycle write strobe. The block serialises them LSB first with one start bit and one stop bit, and holds `tx` high when idle.

## Interface
- `CLOCK_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, serial bit rate.
- `FIFO_DEPTH`, 4, number of byte entries in the write FIFO. Must be a power of two, ≥ 2.
- `DIV`, localparam = floor(CLOCK_HZ / BAUD_RATE), clocks per bit. Default 434. Must be ≥ 2.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe; a byte is pushed on each sampled-high edge while `full`=0.
- `wr_data` in 8: byte to push; sampled with `wr_en`.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries. The byte in the shift register is not counted.
- `busy` out 1: high when a frame is in progress or the FIFO is non-empty.
- `overflow` out 1: sticky flag, set when `wr_en` is sampled high while `full`=1. Cleared only by reset.
- `tx` out 1: serial output, registered.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
  - `full`/`empty` are derived from the registered count.
  - A write is accepted iff `wr_en`=1 and `full`=1 is false.
  - A write while full is dropped: data is not stored, count is unchanged, `overflow` is set.
  - Write and pop in the same cycle when not full: both occur and the count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If FIFO not empty: pop the head into the 8-bit shift register, clear the bit counter and the bit-index, drive `tx`<=0, go to START.
  - START: `tx`=0 for DIV cycles. At bit counter = DIV-1: `tx`<=shift[0], bit-index<=0, go to DATA.
  - DATA: each bit is held DIV cycles. At counter = DIV-1:
    - if bit-index < 7: shift right, `tx`<=next bit, bit-index+1;
    - if bit-index = 7: `tx`<=1, go to STOP.
  - STOP: `tx`=1 for DIV cycles. At counter = DIV-1, go to IDLE.
- **Bit counter:** counts 0..DIV-1, reset to 0 on every state change and on wrap.
- **Data order:** LSB first, 8 data bits, no parity, 1 stop bit.
- **Reset**
  - Values: `tx`=1, `full`=0, `empty`=1, `busy`=0, `overflow`=0, state IDLE, pointers/count 0.
  - Reset asserted mid-frame aborts immediately; `tx` returns to 1 asynchronously and FIFO contents are discarded.
- `busy` = (state != IDLE) | !empty, registered-equivalent: derived only from state and count registers, never from inputs.

## Timing
- **Write to start bit:** `wr_en` sampled at edge N into an empty, idle block. Count becomes 1 after edge N. Pop occurs at edge N+1, so `tx` falls after edge N+1, and `empty` returns to 1 after edge N+1.
- **Frame length:** 10×DIV cycles from the falling `tx` edge to the end of the stop bit.
- **Back-to-back frames:** exactly one extra IDLE cycle (`tx`=1) between frames, so the period is 10×DIV+1 cycles.
- **Bit widths:** every bit, including start and stop, lasts exactly DIV cycles. No drift accumulates across bits.
- **`full` after writes:** asserts in the cycle after the accepted write that fills the FIFO. It deasserts in the cycle after the first pop.
- **`overflow` timing:** rises in the cycle after the offending write.

## Test plan
- **Reset values:** hold `rst_n`=0, then release. Required: `tx`=1, `empty`=1, `full`=0, `busy`=0, `overflow`=0, and `tx` stays 1 for 100 cycles with no writes.
- **Single byte (CLOCK_HZ=16, BAUD_RATE=4, DIV=4):** write 0xA5.
  - Required: `tx` falls 1 cycle after the write edge.
  - Then 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - Then IDLE; `busy` drops after 40 cycles from the fall.
- **Back-to-back:** write 0x55 then 0x0F on consecutive cycles. Required: two frames with bit patterns 1010_1010 and 1111_0000 (LSB first), separated by exactly 1 idle cycle.
- **Fill/overflow (FIFO_DEPTH=4):** write 6 bytes 0x01..0x06 on consecutive cycles.
  - The first byte is popped at the cycle after its write, so 0x01..0x05 are accepted.
  - `full` rises after the 5th write.
  - The 6th write (0x06) is dropped; `overflow`=1.
  - Exactly 5 frames are sent, in order 0x01..0x05.
- **Reset mid-frame:** pull `rst_n` low during data bit 3 of 0xFF with 2 bytes queued. Required: `tx`=1 immediately, `empty`=1 after release, and no further frames.
- **Default rate:** with 50 MHz/115200, write 0x00. Required: `tx` low for 9×434 = 3906 cycles, then high for 434 cycles.
